tft_spi_tx: RTL and testbench
=============================

// Module: tft_spi_tx
// PURPOSE
//  Byte-level SPI transmitter for the 4-wire TFT panel (SCK/MOSI/CS_n/DC). It sits directly
//  downstream of the drawing stages (player, maze, etc.) and consumes their
//  tft_transmit/tft_dc/tft_data/tft_busy handshake. Each accepted byte is serialised MSB-first
//  in SPI mode 0. CS_n stays asserted across closely spaced bytes to maximise pixel throughput.
// PARAMETERS
//  CLK_DIV  2  clk cycles per SCK half-period; legal range 1..255.
//  CS_HOLD  8  idle clk cycles CS_n stays low after a byte before it is released; legal range 1..255.
// PORTS
//  clk       in   1  system clock.
//  rst       in   1  reset, synchronous, active-low.
//  transmit  in   1  one-cycle request strobe; data and dc are sampled in the same cycle.
//  dc        in   1  0 = command byte, 1 = data/parameter byte.
//  data      in   8  byte to send.
//  busy      out  1  high while a byte is in flight; upstream sends only when busy=0.
//  overrun   out  1  one-cycle pulse: transmit arrived while busy=1; that byte is dropped.
//  spi_sck   out  1  serial clock, idles low (CPOL=0, CPHA=0).
//  spi_mosi  out  1  serial data, MSB first.
//  spi_cs_n  out  1  chip select, active low.
//  spi_dc    out  1  registered copy of the dc of the byte being sent or most recently sent.
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge): state IDLE; busy=0, overrun=0, spi_sck=0, spi_mosi=0,
//    spi_cs_n=1, spi_dc=0. Reset wins over everything. A reset mid-byte aborts the byte;
//    CS_n is high and SCK is low on the next cycle.
//  - All outputs are registered. There is no combinational path from inputs to outputs.
//  - Accept: transmit=1 and busy=0 in cycle T latches data and dc. busy=1 from T+1.
//    This keeps upstream (which samples ~busy & ~transmit) from issuing twice.
//  - transmit=1 with busy=1: no state change; overrun=1 at the next cycle only.
//  - States: IDLE -> SHIFT on accept. SHIFT -> LINGER after the last half-period.
//    LINGER -> SHIFT on accept. LINGER -> IDLE when CS_HOLD cycles elapse with no accept.
//  - SHIFT: 16 half-periods h=0..15, each CLK_DIV cycles long. Bit b=7-h/2 is on MOSI during
//    h=2i and h=2i+1. SCK=0 on even h and SCK=1 on odd h, so the panel samples on the rising edge.
//    MOSI and spi_dc change only while SCK=0.
//  - Timing (accept at T, D=CLK_DIV):
//    - T+1: spi_cs_n=0, spi_dc=dc, MOSI=data[7].
//    - T+1+D: first SCK rise.
//    - T+16D: last SCK-high cycle.
//    - T+16D+1: SCK=0, busy=0, state LINGER, CS_n remains 0.
//    Total busy time is exactly 16*D cycles.
//  - LINGER: a down-counter loads CS_HOLD and decrements each cycle. CS_n rises the cycle after
//    it reaches 1, if no accept occurred. An accept in LINGER restarts SHIFT with CS_n held low,
//    and the new spi_dc is applied at T+1, before the first SCK rise.
//  - An accept in the same cycle LINGER expires takes priority: CS_n stays low.
//  - MOSI returns to 0 in IDLE. In LINGER it holds the last bit.
//  - Counters: the half-period counter is 4 bits and the divider counter is 8 bits. Neither wraps
//    beyond its terminal count; both reload on accept.
// TESTING
//  1. CLK_DIV=2, send 0xA5 dc=0 at T:
//     -> 8 SCK rises; MOSI sampled on rises = 1,0,1,0,0,1,0,1; spi_dc=0.
//     -> busy high T+1..T+32; CS_n high again at T+33+CS_HOLD.
//  2. Send 0x2A dc=0, then 0x3C dc=1 the first cycle busy=0:
//     -> CS_n never rises between bytes; spi_dc goes 0->1 while SCK=0; 16 SCK rises total.
//  3. Pulse transmit (0xFF) mid-byte of 0x00:
//     -> overrun=1 for one cycle; the wire still carries 0x00; no extra byte is sent.
//  4. Assert rst=0 during bit 4 of a byte:
//     -> next cycle CS_n=1, SCK=0, MOSI=0, busy=0; the next accepted byte is sent intact.
//  5. CLK_DIV=1, upstream model replays the 0x2A/xh/xl/.../0x2C window sequence:
//     -> decoded stream and dc pattern (0,1,1,1,1,0,1,1,1,1,0) match exactly.
//  6. Two bytes separated by CS_HOLD+3 idle cycles:
//     -> CS_n high for at least 1 cycle between them, and each byte begins with CS_n falling.

Source files
------------

// File: rtl/tft_spi_tx.sv
// Byte-level SPI mode-0 transmitter for a 4-wire TFT panel (SCK/MOSI/CS_n/DC).
// Bytes are shifted out MSB first. CS_n is held low for CS_HOLD idle cycles after a byte
// so that closely spaced bytes share one chip-select window.
module tft_spi_tx #(
    parameter int unsigned CLK_DIV = 2,  // clk cycles per SCK half-period, 1..255
    parameter int unsigned CS_HOLD = 8   // idle cycles CS_n lingers low, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic       dc,
    input  logic [7:0] data,
    output logic       busy,
    output logic       overrun,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc
);

    localparam logic [7:0] DivLoad  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HoldLoad = 8'(CS_HOLD);

    typedef enum logic [1:0] {StIdle, StShift, StLinger} state_t;

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [3:0] half_q, half_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] shreg_q, shreg_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;
    logic       dc_q, dc_d;
    logic       accept;

    // busy is only low in IDLE/LINGER, so an accept always comes from one of those states.
    assign accept = transmit & ~busy_q;

    // Next-state logic: sequencing of half-periods, CS_n linger and the accept reload.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        hold_d    = hold_q;
        shreg_d   = shreg_q;
        busy_d    = busy_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        dc_d      = dc_q;
        overrun_d = transmit & busy_q;

        unique case (state_q)
            StIdle: begin
                mosi_d = 1'b0;
                cs_n_d = 1'b1;
            end
            StShift: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (half_q == 4'd15) begin
                    state_d = StLinger;
                    sck_d   = 1'b0;
                    busy_d  = 1'b0;
                    hold_d  = HoldLoad;
                end else begin
                    half_d = half_q + 4'd1;
                    div_d  = DivLoad;
                    sck_d  = ~sck_q;
                    // Leaving an odd (SCK high) half: present the next bit while SCK is low.
                    if (half_q[0]) begin
                        mosi_d  = shreg_q[6];
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            StLinger: begin
                if (hold_q == 8'd1) begin
                    state_d = StIdle;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Accept overrides the LINGER expiry so CS_n stays low for back-to-back bytes.
        if (accept) begin
            state_d = StShift;
            div_d   = DivLoad;
            half_d  = 4'd0;
            shreg_d = data;
            busy_d  = 1'b1;
            sck_d   = 1'b0;
            mosi_d  = data[7];
            cs_n_d  = 1'b0;
            dc_d    = dc;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            div_q     <= 8'd0;
            half_q    <= 4'd0;
            hold_q    <= 8'd0;
            shreg_q   <= 8'd0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            hold_q    <= hold_d;
            shreg_q   <= shreg_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            dc_q      <= dc_d;
        end
    end

    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;
    assign spi_dc   = dc_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// Bench for tft_spi_tx: a CLK_DIV=2 instance for byte timing and corner cases, and a
// CLK_DIV=1 instance fed by an upstream model replaying a window-address sequence.
module tb_tft_spi_tx;

    localparam int HoldA = 8;
    localparam int HoldB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CLK_DIV=2, CS_HOLD=8
    logic       tx_a = 1'b0, dc_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       busy_a, ov_a, sck_a, mosi_a, cs_a, sdc_a;

    // Instance B: CLK_DIV=1, CS_HOLD=4
    logic       tx_b = 1'b0, dc_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       busy_b, ov_b, sck_b, mosi_b, cs_b, sdc_b;

    tft_spi_tx #(.CLK_DIV(2), .CS_HOLD(HoldA)) dut_a (
        .clk(clk), .rst(rst), .transmit(tx_a), .dc(dc_a), .data(data_a),
        .busy(busy_a), .overrun(ov_a), .spi_sck(sck_a), .spi_mosi(mosi_a),
        .spi_cs_n(cs_a), .spi_dc(sdc_a)
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(HoldB)) dut_b (
        .clk(clk), .rst(rst), .transmit(tx_b), .dc(dc_b), .data(data_b),
        .busy(busy_b), .overrun(ov_b), .spi_sck(sck_b), .spi_mosi(mosi_b),
        .spi_cs_n(cs_b), .spi_dc(sdc_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wire-level decoders: sample MOSI on SCK rises, collect {dc, byte} per 8 bits.
    logic       sck_pa = 1'b0, mosi_pa = 1'b0, dc_pa = 1'b0, cs_pa = 1'b1;
    logic [7:0] sr_a = 8'h00;
    int         nb_a = 0, rises_a = 0, glitch_a = 0, csr_a = 0, csf_a = 0, ovr_a = 0;
    logic [8:0] q_a[$];

    always @(negedge clk) begin
        if (ov_a === 1'b1) ovr_a++;
        if (cs_a === 1'b1 && cs_pa === 1'b0) csr_a++;
        if (cs_a === 1'b0 && cs_pa === 1'b1) csf_a++;
        if (sck_a === 1'b1 && sck_pa === 1'b1 && (mosi_a !== mosi_pa || sdc_a !== dc_pa))
            glitch_a++;
        if (cs_a !== 1'b0) begin
            nb_a = 0;
        end else if (sck_a === 1'b1 && sck_pa === 1'b0) begin
            sr_a = {sr_a[6:0], mosi_a};
            rises_a++;
            nb_a++;
            if (nb_a == 8) begin
                q_a.push_back({sdc_a, sr_a});
                nb_a = 0;
            end
        end
        sck_pa = sck_a; mosi_pa = mosi_a; dc_pa = sdc_a; cs_pa = cs_a;
    end

    logic       sck_pb = 1'b0, mosi_pb = 1'b0, dc_pb = 1'b0;
    logic [7:0] sr_b = 8'h00;
    int         nb_b = 0, glitch_b = 0, ovr_b = 0;
    logic [8:0] q_b[$];

    always @(negedge clk) begin
        if (ov_b === 1'b1) ovr_b++;
        if (sck_b === 1'b1 && sck_pb === 1'b1 && (mosi_b !== mosi_pb || sdc_b !== dc_pb))
            glitch_b++;
        if (cs_b !== 1'b0) begin
            nb_b = 0;
        end else if (sck_b === 1'b1 && sck_pb === 1'b0) begin
            sr_b = {sr_b[6:0], mosi_b};
            nb_b++;
            if (nb_b == 8) begin
                q_b.push_back({sdc_b, sr_b});
                nb_b = 0;
            end
        end
        sck_pb = sck_b; mosi_pb = mosi_b; dc_pb = sdc_b;
    end

    // Called at a negedge; transmit is sampled at the next posedge (cycle T), returns at T+1.
    task automatic send_a(input logic [7:0] d, input logic c);
        tx_a = 1'b1; data_a = d; dc_a = c;
        @(negedge clk);
        tx_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        int k;
        for (k = 0; k < 300; k++) begin
            if (cs_a === 1'b1 && busy_a === 1'b0) break;
            @(negedge clk);
        end
        if (k == 300) chk("idle_timeout_a", 32'(k), 0);
        @(negedge clk);
    endtask

    task automatic wait_not_busy_a();
        int k;
        for (k = 0; k < 300; k++) begin
            if (busy_a === 1'b0) break;
            @(negedge clk);
        end
        if (k == 300) chk("busy_timeout_a", 32'(k), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       exp_msb;
        logic       exp_lsb;
        int         exp_busy;
        int         exp_hold;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       dc;
    } item_t;

    vec_t  vecs[5];
    item_t win[11];

    initial begin
        int n, m, bq, br, bg, bcr, bcf, bo;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 32, HoldA};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 32, HoldA};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 32, HoldA};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 32, HoldA};
        vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 32, HoldA};

        win[0]  = '{8'h2A, 1'b0}; win[1]  = '{8'h00, 1'b1}; win[2]  = '{8'h00, 1'b1};
        win[3]  = '{8'h00, 1'b1}; win[4]  = '{8'hEF, 1'b1}; win[5]  = '{8'h2B, 1'b0};
        win[6]  = '{8'h00, 1'b1}; win[7]  = '{8'h00, 1'b1}; win[8]  = '{8'h01, 1'b1};
        win[9]  = '{8'h3F, 1'b1}; win[10] = '{8'h2C, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_overrun", 32'(ov_a), 0);
        chk("rst_sck", 32'(sck_a), 0);
        chk("rst_mosi", 32'(mosi_a), 0);
        chk("rst_cs_n", 32'(cs_a), 1);
        chk("rst_dc", 32'(sdc_a), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single bytes: first-cycle values, busy length, linger length, decoded byte
        for (int i = 0; i < 5; i++) begin
            wait_idle_a();
            bq = q_a.size(); br = rises_a; bg = glitch_a;
            send_a(vecs[i].data, vecs[i].dc);
            chk("t1_cs_low", 32'(cs_a), 0);
            chk("t1_busy_up", 32'(busy_a), 1);
            chk("t1_dc", 32'(sdc_a), 32'(vecs[i].dc));
            chk("t1_first_mosi", 32'(mosi_a), 32'(vecs[i].exp_msb));
            n = 1;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (!busy_a) break;
                n++;
            end
            chk("busy_cycles", 32'(n), 32'(vecs[i].exp_busy));
            chk("linger_sck", 32'(sck_a), 0);
            chk("linger_mosi_hold", 32'(mosi_a), 32'(vecs[i].exp_lsb));
            m = 0;
            while (cs_a !== 1'b1 && m < 200) begin
                @(negedge clk);
                m++;
            end
            chk("cs_hold_cycles", 32'(m), 32'(vecs[i].exp_hold));
            chk("idle_mosi", 32'(mosi_a), 0);
            @(negedge clk);
            chk("byte_count", 32'(q_a.size() - bq), 1);
            if (q_a.size() > bq) chk("byte_value", 32'(q_a[bq]), 32'({vecs[i].dc, vecs[i].data}));
            chk("sck_rises", 32'(rises_a - br), 8);
            chk("change_while_sck_high", 32'(glitch_a - bg), 0);
        end

        // Back-to-back: second byte accepted in the first LINGER cycle
        wait_idle_a();
        bq = q_a.size(); br = rises_a; bg = glitch_a; bcr = csr_a;
        send_a(8'h2A, 1'b0);
        wait_not_busy_a();
        send_a(8'h3C, 1'b1);
        chk("b2b_dc_new", 32'(sdc_a), 1);
        chk("b2b_sck_low", 32'(sck_a), 0);
        chk("b2b_cs_low", 32'(cs_a), 0);
        wait_idle_a();
        chk("b2b_cs_rises", 32'(csr_a - bcr), 1);
        chk("b2b_rises", 32'(rises_a - br), 16);
        chk("b2b_glitch", 32'(glitch_a - bg), 0);
        chk("b2b_count", 32'(q_a.size() - bq), 2);
        if (q_a.size() >= bq + 2) begin
            chk("b2b_byte0", 32'(q_a[bq]), 32'h02A);
            chk("b2b_byte1", 32'(q_a[bq + 1]), 32'h13C);
        end

        // Overrun: transmit mid-byte is dropped, one-cycle pulse
        wait_idle_a();
        bq = q_a.size(); br = rises_a; bo = ovr_a;
        send_a(8'h00, 1'b0);
        repeat (5) @(negedge clk);
        tx_a = 1'b1; data_a = 8'hFF; dc_a = 1'b1;
        @(negedge clk);
        tx_a = 1'b0;
        chk("ovr_pulse", 32'(ov_a), 1);
        @(negedge clk);
        chk("ovr_clear", 32'(ov_a), 0);
        wait_idle_a();
        chk("ovr_total", 32'(ovr_a - bo), 1);
        chk("ovr_rises", 32'(rises_a - br), 8);
        chk("ovr_count", 32'(q_a.size() - bq), 1);
        if (q_a.size() > bq) chk("ovr_byte", 32'(q_a[bq]), 32'h000);

        // Reset during bit 4 (half-periods 6/7 start at T+13 for CLK_DIV=2)
        wait_idle_a();
        send_a(8'hC3, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs_n", 32'(cs_a), 1);
        chk("mid_rst_sck", 32'(sck_a), 0);
        chk("mid_rst_mosi", 32'(mosi_a), 0);
        chk("mid_rst_busy", 32'(busy_a), 0);
        rst = 1'b1;
        @(negedge clk);
        bq = q_a.size();
        send_a(8'h5A, 1'b1);
        wait_idle_a();
        chk("post_rst_count", 32'(q_a.size() - bq), 1);
        if (q_a.size() > bq) chk("post_rst_byte", 32'(q_a[bq]), 32'h15A);

        // Two bytes separated by CS_HOLD+3 idle cycles: separate CS windows
        wait_idle_a();
        bq = q_a.size(); bcr = csr_a; bcf = csf_a;
        send_a(8'h11, 1'b0);
        wait_not_busy_a();
        repeat (HoldA + 3) @(negedge clk);
        chk("gap_cs_high", 32'(cs_a), 1);
        send_a(8'h22, 1'b1);
        wait_idle_a();
        chk("gap_cs_falls", 32'(csf_a - bcf), 2);
        chk("gap_cs_rises", 32'(csr_a - bcr), 2);
        chk("gap_count", 32'(q_a.size() - bq), 2);
        if (q_a.size() >= bq + 2) begin
            chk("gap_byte0", 32'(q_a[bq]), 32'h011);
            chk("gap_byte1", 32'(q_a[bq + 1]), 32'h122);
        end

        // CLK_DIV=1 upstream replay: sends only when ~busy & ~transmit
        for (int i = 0; i < 11; i++) begin
            int k;
            for (k = 0; k < 200; k++) begin
                if (busy_b === 1'b0 && tx_b === 1'b0) break;
                @(negedge clk);
            end
            if (k == 200) chk("win_timeout", 32'(k), 0);
            tx_b = 1'b1; data_b = win[i].data; dc_b = win[i].dc;
            @(negedge clk);
            tx_b = 1'b0;
        end
        repeat (40) @(negedge clk);
        chk("win_idle_cs", 32'(cs_b), 1);
        chk("win_count", 32'(q_b.size()), 11);
        chk("win_overrun", 32'(ovr_b), 0);
        chk("win_glitch", 32'(glitch_b), 0);
        for (int i = 0; i < 11; i++) begin
            if (i < q_b.size()) chk("win_item", 32'(q_b[i]), 32'({win[i].dc, win[i].data}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
